// File: rtl/cpu_pkg.sv
// cpu_pkg: shared encodings for the 5-stage pipeline control.
// Holds the sequencer state encoding, PC source select encoding,
// register-number width and the canned control-output bundles.
package cpu_pkg;

    localparam int REG_W = 6;

    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_RUN    = 2'd1,
        ST_LSTALL = 2'd2
    } pipe_state_e;

    typedef enum logic [1:0] {
        PCSEL_SEQ = 2'b00,
        PCSEL_EX  = 2'b01,
        PCSEL_MEM = 2'b10
    } pc_sel_e;

    // One cycle's worth of pipeline-register controls.
    typedef struct packed {
        logic    pc_wr;
        pc_sel_e pc_sel;
        logic    ifid_wr;
        logic    ifid_flush;
        logic    idex_flush;
        logic    exmem_flush;
    } pipe_ctrl_t;

    // During fill IF/ID is held and every downstream register is bubbled.
    localparam pipe_ctrl_t CTRL_FILL   = '{pc_wr: 1'b0, pc_sel: PCSEL_SEQ, ifid_wr: 1'b0,
                                           ifid_flush: 1'b1, idex_flush: 1'b1, exmem_flush: 1'b1};
    localparam pipe_ctrl_t CTRL_RUN    = '{pc_wr: 1'b1, pc_sel: PCSEL_SEQ, ifid_wr: 1'b1,
                                           ifid_flush: 1'b0, idex_flush: 1'b0, exmem_flush: 1'b0};
    // Load-use bubble: freeze PC and IF/ID, inject a bubble into ID/EX.
    localparam pipe_ctrl_t CTRL_STALL  = '{pc_wr: 1'b0, pc_sel: PCSEL_SEQ, ifid_wr: 1'b0,
                                           ifid_flush: 1'b0, idex_flush: 1'b1, exmem_flush: 1'b0};
    // EX redirect squashes the two younger instructions (IF/ID, ID/EX).
    localparam pipe_ctrl_t CTRL_EX_RED = '{pc_wr: 1'b1, pc_sel: PCSEL_EX, ifid_wr: 1'b1,
                                           ifid_flush: 1'b1, idex_flush: 1'b1, exmem_flush: 1'b0};
    // MEM redirect squashes the three younger instructions.
    localparam pipe_ctrl_t CTRL_MEM_RED = '{pc_wr: 1'b1, pc_sel: PCSEL_MEM, ifid_wr: 1'b1,
                                            ifid_flush: 1'b1, idex_flush: 1'b1, exmem_flush: 1'b1};

    // Saturating increment for the statistics counters.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// load_use_detect: combinational load-use hazard compare between the
// instruction in ID and a load sitting in EX. r0 is deliberately not
// excluded, so a load to r0 still stalls a dependent reader.
module load_use_detect
    import cpu_pkg::*;
(
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_memread,
    output logic             hazard
);

    assign hazard = ex_memread &&
                    ((id_use_rs && (id_rs == ex_rd)) ||
                     (id_use_rt && (id_rt == ex_rd)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: pipeline sequencer for the 5-stage datapath.
// Drives PC/IF/ID write enables, register flushes and PC source select.
// Runs a post-reset fill, multi-cycle load-use stalls and redirect squashes.
// Optional build macro PIPE_STATS_EN adds stall_cnt / flush_cnt outputs.
module pipe_hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int RST_CYCLES = 2,   // 1..15
    parameter int LOAD_LAT   = 1    // 1..3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_memread,
    input  logic             ex_redirect,
    input  logic             mem_redirect,
    output logic             pc_wr,
    output logic [1:0]       pc_sel,
    output logic             ifid_wr,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic [1:0]       state
`ifdef PIPE_STATS_EN
    ,
    output logic [15:0]      stall_cnt,
    output logic [15:0]      flush_cnt
`endif
);

    localparam logic [3:0] FILL_LAST  = 4'(RST_CYCLES - 1);
    localparam logic [1:0] STALL_INIT = 2'(LOAD_LAT - 1);

    pipe_state_e state_q, state_d;
    logic [3:0]  fill_q, fill_d;
    logic [1:0]  stall_q, stall_d;
    pipe_ctrl_t  ctrl;
    logic        hazard;
    logic        stall_cyc;
    logic        redirect_cyc;

    load_use_detect u_load_use_detect (
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_use_rs  (id_use_rs),
        .id_use_rt  (id_use_rt),
        .ex_rd      (ex_rd),
        .ex_memread (ex_memread),
        .hazard     (hazard)
    );

    // Next-state, counter updates and this cycle's control outputs.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d      = state_q;
        fill_d       = fill_q;
        stall_d      = stall_q;
        ctrl         = CTRL_RUN;
        stall_cyc    = 1'b0;
        redirect_cyc = 1'b0;
        case (state_q)
            ST_FILL: begin
                // Redirects and hazards are ignored until the pipe is filled.
                ctrl = CTRL_FILL;
                if (fill_q == FILL_LAST) begin
                    state_d = ST_RUN;
                    fill_d  = 4'd0;
                end else begin
                    fill_d = fill_q + 4'd1;
                end
            end
            ST_RUN, ST_LSTALL: begin
                if (mem_redirect) begin
                    ctrl         = CTRL_MEM_RED;
                    redirect_cyc = 1'b1;
                    state_d      = ST_RUN;
                    stall_d      = 2'd0;
                end else if (ex_redirect) begin
                    ctrl         = CTRL_EX_RED;
                    redirect_cyc = 1'b1;
                    state_d      = ST_RUN;
                    stall_d      = 2'd0;
                end else if (state_q == ST_LSTALL) begin
                    // The load has left EX; keep bubbling without re-checking.
                    ctrl      = CTRL_STALL;
                    stall_cyc = 1'b1;
                    if (stall_q == 2'd1) begin
                        state_d = ST_RUN;
                        stall_d = 2'd0;
                    end else begin
                        stall_d = stall_q - 2'd1;
                    end
                end else if (hazard) begin
                    ctrl      = CTRL_STALL;
                    stall_cyc = 1'b1;
                    if (LOAD_LAT > 1) begin
                        state_d = ST_LSTALL;
                        stall_d = STALL_INIT;
                    end
                end
            end
            default: begin
                ctrl    = CTRL_FILL;
                state_d = ST_FILL;
                fill_d  = 4'd0;
                stall_d = 2'd0;
            end
        endcase
    end

    // State and counter registers with synchronous reset into FILL.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            state_q <= ST_FILL;
            fill_q  <= 4'd0;
            stall_q <= 2'd0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            stall_q <= stall_d;
        end
    end

    assign pc_wr       = ctrl.pc_wr;
    assign pc_sel      = ctrl.pc_sel;
    assign ifid_wr     = ctrl.ifid_wr;
    assign ifid_flush  = ctrl.ifid_flush;
    assign idex_flush  = ctrl.idex_flush;
    assign exmem_flush = ctrl.exmem_flush;
    assign state       = state_q;

`ifdef PIPE_STATS_EN
    logic [15:0] stall_cnt_q;
    logic [15:0] flush_cnt_q;

    // Saturating counts of load-use bubble cycles and redirect events.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= 16'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            if (stall_cyc)    stall_cnt_q <= sat_inc16(stall_cnt_q);
            if (redirect_cyc) flush_cnt_q <= sat_inc16(flush_cnt_q);
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    // Without statistics the event strobes have no consumer.
    logic unused_stats;
    assign unused_stats = stall_cyc ^ redirect_cyc;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: scoreboard bench for pipe_hazard_ctrl.
// Two instances (different RST_CYCLES / LOAD_LAT) share one stimulus stream;
// each has its own behavioural model and expectation queue.
module tb_pipe_hazard_ctrl;
    import cpu_pkg::*;

    localparam int RC_A = 2, LL_A = 2;
    localparam int RC_B = 3, LL_B = 3;

    typedef struct packed {
        logic [5:0] rs;
        logic [5:0] rt;
        logic       urs;
        logic       urt;
        logic [5:0] rd;
        logic       mr;
        logic       exr;
        logic       memr;
    } stim_t;

    typedef struct packed {
        logic        pc_wr;
        logic [1:0]  pc_sel;
        logic        ifid_wr;
        logic        ifid_flush;
        logic        idex_flush;
        logic        exmem_flush;
        logic [1:0]  state;
        logic [15:0] stall_cnt;
        logic [15:0] flush_cnt;
    } obs_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic [5:0] id_rs = '0, id_rt = '0, ex_rd = '0;
    logic       id_use_rs = 1'b0, id_use_rt = 1'b0, ex_memread = 1'b0;
    logic       ex_redirect = 1'b0, mem_redirect = 1'b0;

    logic       pc_wr_a, ifid_wr_a, ifid_flush_a, idex_flush_a, exmem_flush_a;
    logic [1:0] pc_sel_a, state_a;
    logic       pc_wr_b, ifid_wr_b, ifid_flush_b, idex_flush_b, exmem_flush_b;
    logic [1:0] pc_sel_b, state_b;
    logic [15:0] sc_a, fc_a, sc_b, fc_b;

    pipe_hazard_ctrl #(.RST_CYCLES(RC_A), .LOAD_LAT(LL_A)) u_dut_a (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .ex_rd(ex_rd), .ex_memread(ex_memread),
        .ex_redirect(ex_redirect), .mem_redirect(mem_redirect),
        .pc_wr(pc_wr_a), .pc_sel(pc_sel_a), .ifid_wr(ifid_wr_a),
        .ifid_flush(ifid_flush_a), .idex_flush(idex_flush_a), .exmem_flush(exmem_flush_a),
        .state(state_a)
`ifdef PIPE_STATS_EN
        , .stall_cnt(sc_a), .flush_cnt(fc_a)
`endif
    );

    pipe_hazard_ctrl #(.RST_CYCLES(RC_B), .LOAD_LAT(LL_B)) u_dut_b (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .ex_rd(ex_rd), .ex_memread(ex_memread),
        .ex_redirect(ex_redirect), .mem_redirect(mem_redirect),
        .pc_wr(pc_wr_b), .pc_sel(pc_sel_b), .ifid_wr(ifid_wr_b),
        .ifid_flush(ifid_flush_b), .idex_flush(idex_flush_b), .exmem_flush(exmem_flush_b),
        .state(state_b)
`ifdef PIPE_STATS_EN
        , .stall_cnt(sc_b), .flush_cnt(fc_b)
`endif
    );

`ifndef PIPE_STATS_EN
    assign sc_a = '0;
    assign fc_a = '0;
    assign sc_b = '0;
    assign fc_b = '0;
`endif

    // ---------------- behavioural model ----------------
    int  rc_p[2], ll_p[2];
    bit  in_fill[2];
    int  fill_left[2];   // FILL cycles still to come, including the current one
    int  stall_left[2];  // extra bubble cycles still owed after the hazard cycle
    int  n_stall[2], n_flush[2];

    obs_t exp_q_a[$];
    obs_t exp_q_b[$];

    int  checks = 0;
    int  errors = 0;
    bit  armed = 1'b0;
    bit  drv_done = 1'b0;
    int  cyc = 0;

    function automatic bit is_hazard(input stim_t v);
        return v.mr && ((v.urs && v.rs == v.rd) || (v.urt && v.rt == v.rd));
    endfunction

    // Expected outputs for model k in the current cycle, then advance it one edge.
    task automatic model_cycle(input int k, input logic r, input stim_t v, output obs_t e);
        bit redirect, stall;
        e = '0;
        redirect = 1'b0;
        stall    = 1'b0;
        if (in_fill[k]) begin
            e.ifid_flush = 1'b1; e.idex_flush = 1'b1; e.exmem_flush = 1'b1;
            e.state = 2'd0;
        end else begin
            e.state = (stall_left[k] > 0) ? 2'd2 : 2'd1;
            if (v.memr) begin
                e.pc_wr = 1'b1; e.pc_sel = 2'b10; e.ifid_wr = 1'b1;
                e.ifid_flush = 1'b1; e.idex_flush = 1'b1; e.exmem_flush = 1'b1;
                redirect = 1'b1;
            end else if (v.exr) begin
                e.pc_wr = 1'b1; e.pc_sel = 2'b01; e.ifid_wr = 1'b1;
                e.ifid_flush = 1'b1; e.idex_flush = 1'b1;
                redirect = 1'b1;
            end else if (stall_left[k] > 0 || is_hazard(v)) begin
                e.idex_flush = 1'b1;
                stall = 1'b1;
            end else begin
                e.pc_wr = 1'b1; e.ifid_wr = 1'b1;
            end
        end
`ifdef PIPE_STATS_EN
        e.stall_cnt = 16'(n_stall[k]);
        e.flush_cnt = 16'(n_flush[k]);
`endif
        if (r) begin
            in_fill[k] = 1'b1; fill_left[k] = rc_p[k]; stall_left[k] = 0;
            n_stall[k] = 0; n_flush[k] = 0;
        end else if (in_fill[k]) begin
            fill_left[k]--;
            if (fill_left[k] == 0) in_fill[k] = 1'b0;
        end else if (redirect) begin
            if (n_flush[k] < 65535) n_flush[k]++;
            stall_left[k] = 0;
        end else if (stall) begin
            if (n_stall[k] < 65535) n_stall[k]++;
            if (stall_left[k] > 0) stall_left[k]--;
            else stall_left[k] = ll_p[k] - 1;
        end
    endtask

    // Drive one cycle of inputs, queue expectations, advance to #1 after next edge.
    task automatic drive(input logic r, input stim_t v);
        obs_t ea, eb;
        rst = r;
        id_rs = v.rs; id_rt = v.rt; id_use_rs = v.urs; id_use_rt = v.urt;
        ex_rd = v.rd; ex_memread = v.mr; ex_redirect = v.exr; mem_redirect = v.memr;
        model_cycle(0, r, v, ea);
        model_cycle(1, r, v, eb);
        if (armed) begin
            exp_q_a.push_back(ea);
            exp_q_b.push_back(eb);
        end
        armed = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string name, input obs_t act, input obs_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc %0d got %h want %h", name, cyc, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    initial begin
        obs_t act, exp;
        forever begin
            @(negedge clk);
            if (exp_q_a.size() > 0) begin
                exp = exp_q_a.pop_front();
                act = {pc_wr_a, pc_sel_a, ifid_wr_a, ifid_flush_a, idex_flush_a,
                       exmem_flush_a, state_a, sc_a, fc_a};
                check("dut_a", act, exp);
            end
            if (exp_q_b.size() > 0) begin
                exp = exp_q_b.pop_front();
                act = {pc_wr_b, pc_sel_b, ifid_wr_b, ifid_flush_b, idex_flush_b,
                       exmem_flush_b, state_b, sc_b, fc_b};
                check("dut_b", act, exp);
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog timeout at cyc %0d", cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin
        stim_t idle, v;
        rc_p[0] = RC_A; ll_p[0] = LL_A;
        rc_p[1] = RC_B; ll_p[1] = LL_B;
        idle = '0;

        // Reset held three cycles, then fill and settle into RUN.
        repeat (3) drive(1'b1, idle);
        repeat (5) drive(1'b0, idle);

        // Load-use on rs: stall for LOAD_LAT cycles.
        v = idle; v.mr = 1'b1; v.rd = 6'd5; v.rs = 6'd5; v.urs = 1'b1;
        drive(1'b0, v);
        repeat (4) drive(1'b0, idle);

        // Matching registers but neither operand used: no stall.
        v = idle; v.mr = 1'b1; v.rd = 6'd5; v.rt = 6'd5;
        drive(1'b0, v);
        drive(1'b0, idle);

        // EX redirect in RUN.
        v = idle; v.exr = 1'b1;
        drive(1'b0, v);
        drive(1'b0, idle);

        // MEM redirect, EX redirect and hazard together: MEM wins.
        v = idle; v.memr = 1'b1; v.exr = 1'b1; v.mr = 1'b1; v.rd = 6'd3;
        v.rt = 6'd3; v.urt = 1'b1;
        drive(1'b0, v);
        drive(1'b0, idle);

        // Fresh reset, then hazard with a redirect two cycles later.
        drive(1'b1, idle);
        repeat (4) drive(1'b0, idle);
        v = idle; v.mr = 1'b1; v.rd = 6'd0; v.rs = 6'd0; v.urs = 1'b1;
        drive(1'b0, v);
        drive(1'b0, idle);
        v = idle; v.exr = 1'b1;
        drive(1'b0, v);
`ifdef PIPE_STATS_EN
        checks++;
        if (sc_b !== 16'd2 || fc_b !== 16'd1) begin
            errors++;
            $display("FAIL stats_b got stall %0d flush %0d want 2 1", sc_b, fc_b);
        end
`endif
        repeat (2) drive(1'b0, idle);

        // Randomized traffic with small register ranges to provoke hazards.
        for (int i = 0; i < 600; i++) begin
            v.rs   = 6'($urandom_range(3));
            v.rt   = 6'($urandom_range(3));
            v.rd   = 6'($urandom_range(3));
            v.urs  = 1'($urandom_range(1));
            v.urt  = 1'($urandom_range(1));
            v.mr   = 1'($urandom_range(1));
            v.exr  = ($urandom_range(7) == 0);
            v.memr = ($urandom_range(9) == 0);
            drive(($urandom_range(79) == 0), v);
        end
        drive(1'b0, idle);
        drv_done = 1'b1;

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q_a.size() != 0 || exp_q_b.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d/%0d pending want 0/0", exp_q_a.size(), exp_q_b.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
